// File: rtl/timer_unit.sv
// Memory-mapped 32-bit down-counting timer with CTRL/PRESET/COUNT registers and an IRQ output.
// Optional prescaler on CTRL[7:4] is enabled by defining TIMER_PRESCALE_EN.
module timer_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

   state_t      state;
   logic        en;
   logic [1:0]  mode;
   logic        im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;
   logic        ctrl_we;
   logic        preset_we;
   logic        auto_reload;
   logic        tick;
   logic [31:0] ctrl_word;
   logic        unused_bits;

   assign ctrl_we     = WE && (Addr[3:2] == 2'b00);
   assign preset_we   = WE && (Addr[3:2] == 2'b01);
   assign auto_reload = (mode == 2'b01);
   assign IRQ         = im & irq_flag;

`ifdef TIMER_PRESCALE_EN
   logic [3:0]  ps;
   logic [14:0] psc;
   logic [14:0] ps_mask;

   // Low PS bits of the free-running prescale counter all set marks every 2^PS-th CNT cycle.
   assign ps_mask     = ~(15'h7fff << ps);
   assign tick        = (psc & ps_mask) == ps_mask;
   assign ctrl_word   = {24'd0, ps, im, mode, en};
   assign unused_bits = ^{Addr[31:4], Din[31:8]};
`else
   assign tick        = 1'b1;
   assign ctrl_word   = {28'd0, im, mode, en};
   assign unused_bits = ^{Addr[31:4], Din[31:4]};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         en       <= 1'b0;
         mode     <= 2'b00;
         im       <= 1'b0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
`ifdef TIMER_PRESCALE_EN
         ps       <= '0;
         psc      <= '0;
`endif
      end else begin
         if (preset_we)
            preset <= Din;

         if (ctrl_we)
            irq_flag <= 1'b0;
         else if (state == INT)
            irq_flag <= 1'b1;
         else if (auto_reload)
            irq_flag <= 1'b0;

         case (state)
            IDLE: begin
               if (en)
                  state <= LOAD;
            end
            LOAD: begin
               count <= preset;
               state <= CNT;
`ifdef TIMER_PRESCALE_EN
               psc   <= '0;
`endif
            end
            CNT: begin
               if (!en) begin
                  state <= IDLE;
`ifdef TIMER_PRESCALE_EN
                  psc   <= '0;
`endif
               end else begin
`ifdef TIMER_PRESCALE_EN
                  psc <= psc + 15'd1;
`endif
                  if (tick) begin
                     if (count > 32'd1) begin
                        count <= count - 32'd1;
                     end else begin
                        count <= '0;
                        state <= INT;
`ifdef TIMER_PRESCALE_EN
                        psc   <= '0;
`endif
                     end
                  end
               end
            end
            default: begin
               if (auto_reload) begin
                  state <= LOAD;
               end else begin
                  state <= IDLE;
                  en    <= 1'b0;
               end
            end
         endcase

         // Placed after the state case so a CPU CTRL write overrides the one-shot EN clear.
         if (ctrl_we) begin
            en   <= Din[0];
            mode <= Din[2:1];
            im   <= Din[3];
`ifdef TIMER_PRESCALE_EN
            ps   <= Din[7:4];
`endif
         end
      end
   end

   always_comb begin
      Dout = '0;
      case (Addr[3:2])
         2'b00:   Dout = ctrl_word;
         2'b01:   Dout = preset;
         2'b10:   Dout = count;
         default: Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: directed literal checks plus randomized traffic against
// a behavioural model of the register map and counting rules.
module tb_timer_unit;

   localparam int PH_IDLE = 0;
   localparam int PH_LOAD = 1;
   localparam int PH_CNT  = 2;
   localparam int PH_INT  = 3;
`ifdef TIMER_PRESCALE_EN
   localparam logic [31:0] CTRL_MASK = 32'h0000_00FF;
`else
   localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

   logic        clk;
   logic        reset;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_ctrl, m_preset, m_count;
   int          m_phase, m_cc;
   bit          m_flag;
   bit          m_valid = 1'b0;

   timer_unit dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mread(input logic [1:0] a);
      case (a)
         2'b00:   return m_ctrl;
         2'b01:   return m_preset;
         2'b10:   return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step();
      logic [31:0] c, p, k;
      int ph, cc, period;
      bit f, ar;
      if (reset) begin
         m_ctrl   <= '0;
         m_preset <= '0;
         m_count  <= '0;
         m_phase  <= PH_IDLE;
         m_cc     <= 0;
         m_flag   <= 1'b0;
         m_valid  <= 1'b1;
         return;
      end
      c  = m_ctrl;
      p  = m_preset;
      k  = m_count;
      ph = m_phase;
      cc = m_cc;
      f  = m_flag;
      ar = (m_ctrl[2:1] == 2'b01);
`ifdef TIMER_PRESCALE_EN
      period = 1 << m_ctrl[7:4];
`else
      period = 1;
`endif
      case (m_phase)
         PH_IDLE: if (m_ctrl[0]) ph = PH_LOAD;
         PH_LOAD: begin
            k  = m_preset;
            cc = 0;
            ph = PH_CNT;
         end
         PH_CNT: begin
            if (!m_ctrl[0]) begin
               ph = PH_IDLE;
            end else begin
               cc = m_cc + 1;
               if (cc % period == 0) begin
                  if (m_count > 1) k = m_count - 1;
                  else begin
                     k  = '0;
                     ph = PH_INT;
                  end
               end
            end
         end
         default: begin
            if (ar) ph = PH_LOAD;
            else begin
               ph   = PH_IDLE;
               c[0] = 1'b0;
            end
         end
      endcase
      if (m_phase == PH_INT) f = 1'b1;
      else if (ar) f = 1'b0;
      if (WE && Addr[3:2] == 2'b01) p = Din;
      if (WE && Addr[3:2] == 2'b00) begin
         c = Din & CTRL_MASK;
         f = 1'b0;
      end
      m_ctrl   <= c;
      m_preset <= p;
      m_count  <= k;
      m_phase  <= ph;
      m_cc     <= cc;
      m_flag   <= f;
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (m_valid) begin
         checks++;
         if (IRQ !== (m_ctrl[3] & m_flag)) begin
            errors++;
            $display("FAIL irq t=%0t got=%b expected=%b", $time, IRQ, m_ctrl[3] & m_flag);
         end
         checks++;
         if (Dout !== mread(Addr[3:2])) begin
            errors++;
            $display("FAIL dout t=%0t addr=%0d got=%h expected=%h", $time, Addr[3:2], Dout,
                     mread(Addr[3:2]));
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d);
      WE   = we;
      Addr = {28'd0, a};
      Din  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string name);
      WE   = 1'b0;
      Addr = {28'd0, a};
      #1;
      lit(name, Dout, exp);
   endtask

   initial begin
      logic [16:0] pulses;
      logic        irq_seen;

      reset = 1'b1;
      WE    = 1'b0;
      Addr  = '0;
      Din   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      peek(2'd0, 32'd0, "rst_ctrl");
      peek(2'd1, 32'd0, "rst_preset");
      peek(2'd2, 32'd0, "rst_count");
      peek(2'd3, 32'd0, "rst_addr3");
      lit("rst_irq", {31'd0, IRQ}, 32'd0);

      // One-shot, IM=1, PRESET=5
      step(1'b1, 2'd1, 32'd5);
      step(1'b1, 2'd0, 32'h9);
      step(1'b0, 2'd2, 32'd0);
      step(1'b0, 2'd2, 32'd0);
      peek(2'd2, 32'd5, "os_count5");
      for (int v = 4; v >= 0; v--) begin
         step(1'b0, 2'd2, 32'd0);
         peek(2'd2, 32'(v), "os_count");
      end
      lit("os_irq_before", {31'd0, IRQ}, 32'd0);
      step(1'b0, 2'd0, 32'd0);
      lit("os_irq_rise", {31'd0, IRQ}, 32'd1);
      peek(2'd0, 32'h8, "os_ctrl_after");
      repeat (3) step(1'b0, 2'd0, 32'd0);
      lit("os_irq_held", {31'd0, IRQ}, 32'd1);
      step(1'b1, 2'd0, 32'd0);
      lit("os_irq_clear", {31'd0, IRQ}, 32'd0);

      // Auto-reload, PRESET=3: pulses at edges 6, 11, 16 after the enable write
      step(1'b1, 2'd1, 32'd3);
      step(1'b1, 2'd0, 32'hB);
      pulses = '0;
      for (int k = 1; k <= 16; k++) begin
         step(1'b0, 2'd2, 32'd0);
         pulses[k] = IRQ;
         if (k == 7 || k == 12) lit("ar_reload", Dout, 32'd3);
      end
      lit("ar_pulses", {15'd0, pulses}, 32'h0001_0840);
      step(1'b1, 2'd0, 32'd0);
      repeat (3) step(1'b0, 2'd0, 32'd0);

      // IM=0 one-shot, PRESET=2
      step(1'b1, 2'd1, 32'd2);
      step(1'b1, 2'd0, 32'h1);
      irq_seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 2'd0, 32'd0);
         irq_seen |= IRQ;
      end
      lit("im0_irq", {31'd0, irq_seen}, 32'd0);
      peek(2'd0, 32'd0, "im0_ctrl");
      peek(2'd2, 32'd0, "im0_count");

      // PRESET write mid-count, then disable and re-enable
      step(1'b1, 2'd1, 32'd10);
      step(1'b1, 2'd0, 32'h1);
      repeat (8) step(1'b0, 2'd2, 32'd0);
      lit("mid_count4", Dout, 32'd4);
      step(1'b1, 2'd1, 32'd100);
      step(1'b1, 2'd0, 32'd0);
      repeat (3) step(1'b0, 2'd2, 32'd0);
      lit("mid_hold", Dout, 32'd2);
      peek(2'd1, 32'd100, "mid_preset");
      step(1'b1, 2'd0, 32'h1);
      step(1'b0, 2'd2, 32'd0);
      step(1'b0, 2'd2, 32'd0);
      lit("mid_reload", Dout, 32'd100);
      step(1'b1, 2'd0, 32'd0);
      repeat (3) step(1'b0, 2'd0, 32'd0);

`ifdef TIMER_PRESCALE_EN
      // PS=2: COUNT steps every 4 cycles
      step(1'b1, 2'd1, 32'd2);
      step(1'b1, 2'd0, 32'h29);
      step(1'b0, 2'd2, 32'd0);
      step(1'b0, 2'd2, 32'd0);
      lit("ps_count2", Dout, 32'd2);
      repeat (3) step(1'b0, 2'd2, 32'd0);
      lit("ps_count2_held", Dout, 32'd2);
      step(1'b0, 2'd2, 32'd0);
      lit("ps_count1", Dout, 32'd1);
      repeat (4) step(1'b0, 2'd2, 32'd0);
      lit("ps_count0", Dout, 32'd0);
      lit("ps_irq_before", {31'd0, IRQ}, 32'd0);
      step(1'b0, 2'd2, 32'd0);
      lit("ps_irq_rise", {31'd0, IRQ}, 32'd1);
      step(1'b1, 2'd0, 32'd0);
`endif

      // Randomized traffic, including resets that collide with writes
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 49) == 0);
         WE    = ($urandom_range(0, 3) == 0);
         Addr  = 30'($urandom());
         Din   = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 8));
`ifdef TIMER_PRESCALE_EN
         if (Addr[3:2] == 2'b00) Din[7:6] = 2'b00;
`endif
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      WE    = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
